// File: rtl/obs_pkg.sv
// Shared types and constants for the obstacle scheduler.
package obs_pkg;
    localparam int NUM_SLOTS = 3;
    localparam int X_W       = 13;
    localparam int GAP_W     = 10;

    localparam logic [1:0] OBS_SMALL = 2'd0;
    localparam logic [1:0] OBS_BIG   = 2'd1;
    localparam logic [1:0] OBS_PTERO = 2'd2;

    localparam int SMALL_W = 17;
    localparam int BIG_W   = 25;
    localparam int PTERO_W = 46;
    localparam int SPRITE_MAX_W = (PTERO_W > BIG_W) ?
                                  ((PTERO_W > SMALL_W) ? PTERO_W : SMALL_W) :
                                  ((BIG_W > SMALL_W) ? BIG_W : SMALL_W);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FROZEN} state_t;
endpackage

// File: rtl/obstacle_scheduler_if.sv
// Game-FSM controls in, obstacle slot state out.
interface obstacle_scheduler_if;
    import obs_pkg::*;
    logic                    frame_tick;
    logic                    game_run;
    logic                    game_clear;
    logic                    collision;
    logic [3:0]              speed;
    logic signed [X_W-1:0]   cactus_x [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    cactus_active;
    logic [1:0]              cactus_type [NUM_SLOTS];
    logic                    frozen;

    modport master (output frame_tick, game_run, game_clear, collision, speed,
                    input  cactus_x, cactus_active, cactus_type, frozen);
    modport slave  (input  frame_tick, game_run, game_clear, collision, speed,
                    output cactus_x, cactus_active, cactus_type, frozen);
endinterface

// File: rtl/obs_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); exposes its low OUT_W bits.
module obs_lfsr16 #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] q
);
    logic [15:0] r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= SEED;
        else        r <= {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    end

    assign q = r[OUT_W-1:0];
endmodule

// File: rtl/obstacle_scheduler.sv
// Three-slot obstacle spawner/scroller. Define OBS_PTERO_EN to allow pterodactyl spawns.
module obstacle_scheduler
    import obs_pkg::*;
#(
    parameter int          SCREEN_W  = 640,
    parameter int          OBS_MAX_W = SPRITE_MAX_W,
    parameter int          MIN_GAP   = 220,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    obstacle_scheduler_if.slave  bus
);
`ifdef OBS_PTERO_EN
    localparam int RND_W = 10;
`else
    localparam int RND_W = 9;
`endif
    localparam logic signed [X_W-1:0] SPAWN_X  = X_W'(SCREEN_W);
    localparam logic signed [X_W-1:0] RETIRE_X = X_W'(-OBS_MAX_W);

    state_t                  state, state_nxt;
    logic signed [X_W-1:0]   x [NUM_SLOTS];
    logic signed [X_W-1:0]   x_nxt [NUM_SLOTS];
    logic [1:0]              typ [NUM_SLOTS];
    logic [1:0]              typ_nxt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    act, act_nxt;
    logic [GAP_W-1:0]        gap, gap_nxt, next_gap, next_gap_nxt;
    logic [GAP_W:0]          gap_sum;
    logic [RND_W-1:0]        rnd;
    logic [1:0]              spawn_type;
    logic                    spawned;

    obs_lfsr16 #(.SEED(LFSR_SEED), .OUT_W(RND_W)) u_lfsr (.clk(clk), .rst_n(rst_n), .q(rnd));

`ifdef OBS_PTERO_EN
    assign spawn_type = (rnd[9:8] == 2'd3) ? OBS_SMALL : rnd[9:8];
`else
    assign spawn_type = {1'b0, rnd[8]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            act      <= '0;
            gap      <= '0;
            next_gap <= GAP_W'(MIN_GAP);
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x[i]   <= '0;
                typ[i] <= OBS_SMALL;
            end
        end else begin
            state    <= state_nxt;
            act      <= act_nxt;
            gap      <= gap_nxt;
            next_gap <= next_gap_nxt;
            x        <= x_nxt;
            typ      <= typ_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        act_nxt      = act;
        gap_nxt      = gap;
        next_gap_nxt = next_gap;
        x_nxt        = x;
        typ_nxt      = typ;
        spawned      = 1'b0;
        gap_sum      = {1'b0, gap} + (GAP_W + 1)'(bus.speed);

        if (bus.game_clear) begin
            state_nxt    = ST_IDLE;
            act_nxt      = '0;
            gap_nxt      = '0;
            next_gap_nxt = GAP_W'(MIN_GAP);
        end else begin
            unique case (state)
                ST_IDLE: if (bus.game_run) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (bus.collision) begin
                        state_nxt = ST_FROZEN;
                    end else if (!bus.game_run) begin
                        state_nxt = ST_IDLE;
                    end else if (bus.frame_tick) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (act[i]) begin
                                x_nxt[i] = x[i] - X_W'(bus.speed);
                                if (x_nxt[i] <= RETIRE_X) act_nxt[i] = 1'b0;
                            end
                        end
                        gap_nxt = gap_sum[GAP_W] ? '1 : gap_sum[GAP_W-1:0];
                        // Free slots come from the pre-tick mask, so a slot retiring now waits a tick.
                        if (bus.speed != 4'd0 && gap_nxt >= next_gap) begin
                            for (int i = 0; i < NUM_SLOTS; i++) begin
                                if (!act[i] && !spawned) begin
                                    spawned    = 1'b1;
                                    act_nxt[i] = 1'b1;
                                    x_nxt[i]   = SPAWN_X;
                                    typ_nxt[i] = spawn_type;
                                end
                            end
                        end
                        if (spawned) begin
                            gap_nxt      = '0;
                            next_gap_nxt = GAP_W'(MIN_GAP) + {2'b00, rnd[7:0]};
                        end
                    end
                end
                ST_FROZEN: ;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.cactus_x      = x;
    assign bus.cactus_type   = typ;
    assign bus.cactus_active = act;
    assign bus.frozen        = (state == ST_FROZEN);
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomized bench for obstacle_scheduler against a frame-level behavioural model.
module tb_obstacle_scheduler;
    localparam int          SCREEN_W  = 640;
    localparam int          OBS_MAX_W = 46;
    localparam int          MIN_GAP   = 220;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    obstacle_scheduler_if bus();

    obstacle_scheduler #(
        .SCREEN_W(SCREEN_W), .OBS_MAX_W(OBS_MAX_W), .MIN_GAP(MIN_GAP), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: game mode as two flags, positions as plain ints.
    int          mx [3];
    int          mt [3];
    bit [2:0]    ma;
    bit          m_run, m_frozen;
    int          m_gap, m_ng;
    logic [15:0] m_lfsr;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin mx[i] = 0; mt[i] = 0; end
        ma = '0; m_run = 0; m_frozen = 0; m_gap = 0; m_ng = MIN_GAP; m_lfsr = SEED;
    endtask

    task automatic model_step(input bit run, input bit clr, input bit col, input bit tk, input int spd);
        bit [2:0] free;
        bit done;
        int sel;
        free = ~ma;
        done = 0;
        if (clr) begin
            m_run = 0; m_frozen = 0; ma = '0; m_gap = 0; m_ng = MIN_GAP;
        end else if (m_run) begin
            if (col) begin
                m_run = 0; m_frozen = 1;
            end else if (!run) begin
                m_run = 0;
            end else if (tk) begin
                for (int i = 0; i < 3; i++)
                    if (ma[i]) begin
                        mx[i] = mx[i] - spd;
                        if (mx[i] <= -OBS_MAX_W) ma[i] = 0;
                    end
                m_gap = (m_gap + spd > 1023) ? 1023 : m_gap + spd;
                if (spd != 0 && m_gap >= m_ng) begin
                    for (int i = 0; i < 3; i++)
                        if (free[i] && !done) begin
                            done = 1;
                            ma[i] = 1;
                            mx[i] = SCREEN_W;
                            sel = (int'(m_lfsr) >> 8) % 4;
`ifdef OBS_PTERO_EN
                            mt[i] = (sel == 3) ? 0 : sel;
`else
                            mt[i] = sel % 2;
`endif
                        end
                    if (done) begin
                        m_gap = 0;
                        m_ng = MIN_GAP + int'(m_lfsr) % 256;
                    end
                end
            end
        end else if (!m_frozen && run) begin
            m_run = 1;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s x%0d", tag, i), int'(bus.cactus_x[i]), mx[i]);
            chk($sformatf("%s type%0d", tag, i), int'(bus.cactus_type[i]), mt[i]);
        end
        chk({tag, " active"}, int'(bus.cactus_active), int'(ma));
        chk({tag, " frozen"}, int'(bus.frozen), int'(m_frozen));
    endtask

    // Called at a negedge: drive, predict the next posedge, compare at the following negedge.
    task automatic cycle(input bit run, input bit clr, input bit col, input bit tk, input int spd);
        bus.game_run   = run;
        bus.game_clear = clr;
        bus.collision  = col;
        bus.frame_tick = tk;
        bus.speed      = 4'(spd);
        model_step(run, clr, col, tk, spd);
        @(negedge clk);
        check_all("cyc");
    endtask

    initial begin
        int xsave;
        int spd;
        bus.game_run = 0; bus.game_clear = 0; bus.collision = 0; bus.frame_tick = 0; bus.speed = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // First spawn lands on tick 55 with speed 4 and MIN_GAP 220.
        cycle(1, 0, 0, 0, 4);
        for (int t = 1; t <= 60; t++) begin
            cycle(1, 0, 0, 1, 4);
            if (t == 54) chk("pre_spawn_active", int'(bus.cactus_active), 0);
            if (t == 55) begin
                chk("spawn_active", int'(bus.cactus_active), 1);
                chk("spawn_x0", int'(bus.cactus_x[0]), SCREEN_W);
            end
            if (t == 56) chk("scroll_x0", int'(bus.cactus_x[0]), SCREEN_W - 4);
            cycle(1, 0, 0, 0, 4);
        end

        // Collision with tick: no move, then field stays frozen until clear.
        xsave = SCREEN_W - 4 * 5;
        cycle(1, 0, 1, 1, 4);
        chk("col_frozen", int'(bus.frozen), 1);
        chk("col_x0_held", int'(bus.cactus_x[0]), xsave);
        repeat (3) cycle(1, 0, 0, 1, 7);
        chk("frozen_x0_held", int'(bus.cactus_x[0]), xsave);
        cycle(1, 1, 0, 0, 4);
        chk("clear_active", int'(bus.cactus_active), 0);
        chk("clear_frozen", int'(bus.frozen), 0);

        // Slow crawl so a slot passes exactly through the retirement threshold.
        for (int t = 0; t < 700; t++) cycle(1, 0, 0, 1, 2);

        for (int n = 0; n < 5000; n++) begin
            spd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
            cycle($urandom_range(0, 39) != 0, $urandom_range(0, 149) == 0,
                  $urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, spd);
        end

        // Asynchronous reset mid-cycle must clear outputs before the next edge.
        cycle(1, 0, 0, 1, 9);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) cycle(1, 0, 0, 1, int'($urandom_range(1, 15)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
